// File: rtl/bsg_gateway_clk_seq_pkg.sv
// -----------------------------------------------------------------------------
// bsg_gateway_clk_seq_pkg
//   Shared definitions for the gateway clock lock-monitor / reset sequencer:
//   the 3-bit FSM state encoding (also exported on state_o for software
//   readback) and a helper that sizes saturating counters.
// -----------------------------------------------------------------------------
package bsg_gateway_clk_seq_pkg;

    localparam int state_width_lp = 3;

    // Encodings are fixed because firmware decodes state_o directly.
    typedef enum logic [state_width_lp-1:0] {
        e_reset_gen = 3'd0,
        e_wait_lock = 3'd1,
        e_stable    = 3'd2,
        e_seq       = 3'd3,
        e_run       = 3'd4,
        e_fault     = 3'd5
    } state_e;

    // Width of a counter that must hold 0..limit (never narrower than 1 bit).
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/bsg_gateway_clk_lock_sync.sv
// -----------------------------------------------------------------------------
// bsg_gateway_clk_lock_sync
//   Plain two-flop synchroniser bringing asynchronous generator lock flags
//   into the clk_i domain.
//
//   Ports:
//     clk_i  in   destination clock
//     d_i    in   asynchronous inputs  [width_p]
//     q_o    out  synchronised outputs [width_p]
// -----------------------------------------------------------------------------
module bsg_gateway_clk_lock_sync
    import bsg_gateway_clk_seq_pkg::*;
#(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] r_meta;
    logic [width_p-1:0] r_sync;

    // NOTE: synchroniser flops carry no reset; they settle within two cycles
    // of any input and a reset term would only add logic in front of the
    // metastability-resolving stage.
    always_ff @(posedge clk_i) begin
        r_meta <= d_i;
        r_sync <= r_meta;
    end

    assign q_o = r_sync;

endmodule

// File: rtl/bsg_gateway_clk_seq.sv
// -----------------------------------------------------------------------------
// bsg_gateway_clk_seq
//   Lock monitor and reset sequencer for the gateway clock generators.
//   Holds the generators in reset for a fixed pulse, waits for every
//   generator to lock, requires the lock to be stable for a qualification
//   window, then releases the downstream domain resets one by one
//   (index 0 first).  Any lock loss after qualification re-asserts all domain
//   resets and restarts the generators; after max_retry_p restarts without
//   reaching RUN the block parks in FAULT until reset_i.
//
//   Ports:
//     clk_i           in   free-running reference clock
//     reset_i         in   synchronous active-high reset
//     gen_locked_i    in   asynchronous generator lock flags    [num_gen_p]
//     gen_rst_o       out  generator reset, all bits identical  [num_gen_p]
//     domain_reset_o  out  per-domain synchronous reset         [num_domain_p]
//     locked_o        out  high only in RUN
//     fault_o         out  high only in FAULT
//     retry_count_o   out  restarts since last RUN
//     state_o         out  encoded FSM state
//     loss_count_o    out  per-generator lock-loss counters, 16 bits each
//                          (only when BSG_GATEWAY_CLK_SEQ_LOSS_CNT_EN is defined)
// -----------------------------------------------------------------------------
module bsg_gateway_clk_seq
    import bsg_gateway_clk_seq_pkg::*;
#(
    parameter int num_gen_p             = 3,
    parameter int num_domain_p          = 4,
    parameter int gen_rst_cycles_p      = 16,
    parameter int stable_cycles_p       = 1024,
    parameter int seq_gap_cycles_p      = 8,
    parameter int lock_timeout_cycles_p = 65536,
    parameter int max_retry_p           = 3
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_gen_p-1:0]               gen_locked_i,
    output logic [num_gen_p-1:0]               gen_rst_o,
    output logic [num_domain_p-1:0]            domain_reset_o,
    output logic                               locked_o,
    output logic                               fault_o,
    output logic [$clog2(max_retry_p+1)-1:0]   retry_count_o,
    output logic [state_width_lp-1:0]          state_o
`ifdef BSG_GATEWAY_CLK_SEQ_LOSS_CNT_EN
    ,
    output logic [num_gen_p*16-1:0]            loss_count_o
`endif
);

    localparam int gen_cnt_w_lp    = cnt_width(gen_rst_cycles_p);
    localparam int stable_cnt_w_lp = cnt_width(stable_cycles_p);
    localparam int lock_cnt_w_lp   = cnt_width(lock_timeout_cycles_p);
    localparam int seq_limit_lp    = (num_domain_p - 1) * seq_gap_cycles_p;
    localparam int seq_cnt_w_lp    = cnt_width(seq_limit_lp);
    localparam int retry_w_lp      = $clog2(max_retry_p + 1);

    localparam logic [gen_cnt_w_lp-1:0]    gen_last_lp    = gen_cnt_w_lp'(gen_rst_cycles_p - 1);
    localparam logic [stable_cnt_w_lp-1:0] stable_last_lp = stable_cnt_w_lp'(stable_cycles_p - 1);
    localparam logic [lock_cnt_w_lp-1:0]   lock_last_lp   = lock_cnt_w_lp'(lock_timeout_cycles_p - 1);
    localparam logic [seq_cnt_w_lp-1:0]    seq_last_lp    = seq_cnt_w_lp'(seq_limit_lp);
    localparam logic [retry_w_lp-1:0]      retry_max_lp   = retry_w_lp'(max_retry_p);

    // ---------------------------------------------------------------------
    // Lock synchronisation: only the AND of the synced flags drives the FSM.
    // ---------------------------------------------------------------------
    logic [num_gen_p-1:0] w_locked_sync;
    logic                 w_all_locked;

    bsg_gateway_clk_lock_sync #(
        .width_p (num_gen_p)
    ) u_lock_sync (
        .clk_i (clk_i),
        .d_i   (gen_locked_i),
        .q_o   (w_locked_sync)
    );

    assign w_all_locked = &w_locked_sync;

    // ---------------------------------------------------------------------
    // State and counters
    // ---------------------------------------------------------------------
    state_e                      r_state;
    logic                        r_gen_rst;
    logic [num_domain_p-1:0]     r_domain_reset;
    logic                        r_locked;
    logic                        r_fault;
    logic [retry_w_lp-1:0]       r_retry;
    logic [gen_cnt_w_lp-1:0]     r_gen_cnt;
    logic [stable_cnt_w_lp-1:0]  r_stable_cnt;
    logic [lock_cnt_w_lp-1:0]    r_lock_cnt;
    logic [seq_cnt_w_lp-1:0]     r_seq_cnt;

    logic                        w_fail;
    logic [num_domain_p-1:0]     w_release;

    // A failure is a lock timeout or any lock loss once sequencing has begun.
    // Evaluated ahead of the state case so lock loss in the last SEQ cycle
    // beats the RUN transition.
    assign w_fail = ((r_state == e_wait_lock) && !w_all_locked && (r_lock_cnt == lock_last_lp))
                 || (((r_state == e_seq) || (r_state == e_run)) && !w_all_locked);

    // Domain k (k >= 1) is released on the edge that makes the SEQ cycle
    // count equal k*seq_gap_cycles_p; domain 0 is released on SEQ entry.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        w_release = '0;
        for (int k = 1; k < num_domain_p; k++) begin
            if (int'(r_seq_cnt) + 1 == k * seq_gap_cycles_p) begin
                w_release[k] = 1'b1;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state        <= e_reset_gen;
            r_gen_rst      <= 1'b1;
            r_domain_reset <= '1;
            r_locked       <= 1'b0;
            r_fault        <= 1'b0;
            r_retry        <= '0;
            r_gen_cnt      <= '0;
            r_stable_cnt   <= '0;
            r_lock_cnt     <= '0;
            r_seq_cnt      <= '0;
        end else if (w_fail) begin
            r_domain_reset <= '1;
            r_locked       <= 1'b0;
            r_gen_rst      <= 1'b1;
            r_gen_cnt      <= '0;
            r_stable_cnt   <= '0;
            r_lock_cnt     <= '0;
            r_seq_cnt      <= '0;
            if (r_retry < retry_max_lp) begin
                r_retry <= r_retry + retry_w_lp'(1);
                r_state <= e_reset_gen;
            end else begin
                r_state <= e_fault;
                r_fault <= 1'b1;
            end
        end else begin
            case (r_state)
                e_reset_gen: begin
                    if (r_gen_cnt == gen_last_lp) begin
                        r_state    <= e_wait_lock;
                        r_gen_rst  <= 1'b0;
                        r_gen_cnt  <= '0;
                        r_lock_cnt <= '0;
                    end else begin
                        r_gen_cnt <= r_gen_cnt + gen_cnt_w_lp'(1);
                    end
                end

                e_wait_lock: begin
                    if (w_all_locked) begin
                        r_state      <= e_stable;
                        r_stable_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + lock_cnt_w_lp'(1);
                    end
                end

                e_stable: begin
                    // A glitch before qualification is not charged as a retry.
                    if (!w_all_locked) begin
                        r_state      <= e_wait_lock;
                        r_stable_cnt <= '0;
                        r_lock_cnt   <= '0;
                    end else if (r_stable_cnt == stable_last_lp) begin
                        r_state           <= e_seq;
                        r_seq_cnt         <= '0;
                        r_domain_reset[0] <= 1'b0;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + stable_cnt_w_lp'(1);
                    end
                end

                e_seq: begin
                    if (r_seq_cnt == seq_last_lp) begin
                        r_state  <= e_run;
                        r_locked <= 1'b1;
                        r_retry  <= '0;
                    end else begin
                        r_seq_cnt      <= r_seq_cnt + seq_cnt_w_lp'(1);
                        r_domain_reset <= r_domain_reset & ~w_release;
                    end
                end

                e_run: begin
                    r_locked <= 1'b1;
                end

                e_fault: begin
                    r_gen_rst      <= 1'b1;
                    r_domain_reset <= '1;
                    r_fault        <= 1'b1;
                end

                default: begin
                    r_state        <= e_reset_gen;
                    r_gen_rst      <= 1'b1;
                    r_domain_reset <= '1;
                    r_gen_cnt      <= '0;
                end
            endcase
        end
    end

    assign gen_rst_o      = {num_gen_p{r_gen_rst}};
    assign domain_reset_o = r_domain_reset;
    assign locked_o       = r_locked;
    assign fault_o        = r_fault;
    assign retry_count_o  = r_retry;
    assign state_o        = r_state;

`ifdef BSG_GATEWAY_CLK_SEQ_LOSS_CNT_EN
    // ---------------------------------------------------------------------
    // Per-generator lock-loss counters (falling edges of the synced flag
    // while the domains are being or have been released).
    // ---------------------------------------------------------------------
    logic [num_gen_p-1:0]       r_locked_prev;
    logic [num_gen_p-1:0][15:0] r_loss_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_locked_prev <= '0;
            r_loss_cnt    <= '0;
        end else begin
            r_locked_prev <= w_locked_sync;
            for (int g = 0; g < num_gen_p; g++) begin
                if (((r_state == e_seq) || (r_state == e_run))
                    && r_locked_prev[g] && !w_locked_sync[g]
                    && (r_loss_cnt[g] != 16'hFFFF)) begin
                    r_loss_cnt[g] <= r_loss_cnt[g] + 16'd1;
                end
            end
        end
    end

    assign loss_count_o = r_loss_cnt;
`endif

endmodule
